// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the Sobel datapath: tracks raster position, tags results, emits markers.
// Optional SOBEL_CTRL_BORDER_ZERO_EN emits border results as zero instead of dropping them.
module sobel_frame_ctrl #(
    parameter int unsigned WIDTH_P     = 8,
    parameter int unsigned IMG_W_P     = 16,
    parameter int unsigned IMG_H_P     = 16,
    parameter int unsigned TAG_DEPTH_P = 4
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    input  logic [WIDTH_P-1:0]          data_i,
    output logic                        dp_valid_o,
    input  logic                        dp_ready_i,
    output logic [WIDTH_P-1:0]          dp_data_o,
    input  logic                        dp_valid_i,
    output logic                        dp_ready_o,
    input  logic signed [2*WIDTH_P-1:0] dp_gx_i,
    input  logic signed [2*WIDTH_P-1:0] dp_gy_i,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic signed [2*WIDTH_P-1:0] gx_o,
    output logic signed [2*WIDTH_P-1:0] gy_o,
    output logic                        sof_o,
    output logic                        eol_o,
    output logic                        busy_o,
    output logic                        frame_done_o,
    output logic                        err_o
);

    localparam int unsigned CW = $clog2(IMG_W_P);
    localparam int unsigned RW = $clog2(IMG_H_P);
    localparam int unsigned AW = $clog2(TAG_DEPTH_P);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            err_q, err_d;
    logic            frame_done_q, frame_done_d;

    // Tag bits: [2] keep, [1] sof, [0] eol
    logic [2:0]      tag_mem_q [TAG_DEPTH_P];
    logic [2:0]      tag_in;
    logic [2:0]      head;

    logic full, empty, in_open, accept, push, pop;
    logic col_last, row_last, keep;

    assign full     = (count_q == (AW+1)'(TAG_DEPTH_P));
    assign empty    = (count_q == '0);
    assign head     = tag_mem_q[rd_ptr_q];
    assign col_last = (col_q == CW'(IMG_W_P - 1));
    assign row_last = (row_q == RW'(IMG_H_P - 1));
    assign keep     = (col_q >= CW'(2)) && (row_q >= RW'(2));

    always_comb begin
        in_open    = ~full & (state_q != StDrain);
        ready_o    = dp_ready_i & in_open;
        dp_valid_o = valid_i & in_open;
        dp_data_o  = data_i;
        accept     = valid_i & ready_o;
        push       = accept;
`ifdef SOBEL_CTRL_BORDER_ZERO_EN
        tag_in     = {keep, (col_q == '0) && (row_q == '0), col_last};
`else
        tag_in     = {keep, (col_q == CW'(2)) && (row_q == RW'(2)), keep & col_last};
`endif
    end

    always_comb begin
`ifdef SOBEL_CTRL_BORDER_ZERO_EN
        valid_o    = dp_valid_i & ~empty;
        // Border beats are emitted too, so they must honour downstream back-pressure.
        dp_ready_o = empty | ready_i;
        gx_o       = head[2] ? dp_gx_i : '0;
        gy_o       = head[2] ? dp_gy_i : '0;
`else
        valid_o    = dp_valid_i & head[2] & ~empty;
        dp_ready_o = empty | ~head[2] | ready_i;
        gx_o       = dp_gx_i;
        gy_o       = dp_gy_i;
`endif
        sof_o      = ~empty & head[1];
        eol_o      = ~empty & head[0];
        pop        = dp_valid_i & dp_ready_o & ~empty;
        busy_o       = (state_q != StIdle);
        frame_done_o = frame_done_q;
        err_o        = err_q;
    end

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        frame_done_d = 1'b0;
        err_d        = err_q | (dp_valid_i & empty);

        if (accept) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end

        unique case (state_q)
            StIdle:  if (accept) state_d = StRun;
            StRun:   if (accept && col_last && row_last) state_d = StDrain;
            StDrain: begin
                if (empty) begin
                    state_d      = StIdle;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= StIdle;
            col_q        <= '0;
            row_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            err_q        <= err_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Tag storage needs no reset; every read is qualified by a non-empty FIFO.
    always_ff @(posedge clk_i) begin
        if (push) tag_mem_q[wr_ptr_q] <= tag_in;
    end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Scoreboard bench for sobel_frame_ctrl on a 4x4 frame with a 2-cycle ideal datapath model.
module tb_sobel_frame_ctrl;

    localparam int W   = 4;
    localparam int H   = 4;
    localparam int TD  = 4;
    localparam int LAT = 2;
`ifdef SOBEL_CTRL_BORDER_ZERO_EN
    localparam int FB    = W * H;
    localparam int OUT_W = W;
`else
    localparam int FB    = (W - 2) * (H - 2);
    localparam int OUT_W = W - 2;
`endif

    logic clk_i = 1'b0;
    logic rstn_i;
    logic valid_i, ready_o;
    logic [7:0] data_i;
    logic dp_valid_o, dp_ready_i;
    logic [7:0] dp_data_o;
    logic dp_valid_i, dp_ready_o;
    logic signed [15:0] dp_gx_i, dp_gy_i;
    logic valid_o, ready_i;
    logic signed [15:0] gx_o, gy_o;
    logic sof_o, eol_o, busy_o, frame_done_o, err_o;

    sobel_frame_ctrl #(
        .WIDTH_P(8), .IMG_W_P(W), .IMG_H_P(H), .TAG_DEPTH_P(TD)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
        .dp_valid_o(dp_valid_o), .dp_ready_i(dp_ready_i), .dp_data_o(dp_data_o),
        .dp_valid_i(dp_valid_i), .dp_ready_o(dp_ready_o), .dp_gx_i(dp_gx_i), .dp_gy_i(dp_gy_i),
        .valid_o(valid_o), .ready_i(ready_i), .gx_o(gx_o), .gy_o(gy_o),
        .sof_o(sof_o), .eol_o(eol_o), .busy_o(busy_o),
        .frame_done_o(frame_done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic [7:0] d; int due; } dp_ent_t;
    typedef struct { logic signed [15:0] gx; logic signed [15:0] gy; logic sof; logic eol; } exp_t;

    dp_ent_t dp_q[$];
    exp_t    sb_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int to_send = 0;
    int pix_k = 0;
    logic [7:0] pix_val = 8'h10;
    logic in_drain = 1'b0;
    int done_cnt = 0;
    int beats = 0;
    int outstanding = 0;
    int full_hits = 0;
    int stall_from = 0;
    int stall_to = 0;
    int last_beat_cyc = 0;
    int done_cyc = 0;

    function automatic logic signed [15:0] res_gx(input logic [7:0] d);
        return $signed({8'h00, d});
    endfunction

    function automatic logic signed [15:0] res_gy(input logic [7:0] d);
        return $signed({d, 8'h5A});
    endfunction

    task automatic clear_model();
        dp_q.delete();
        sb_q.delete();
        pix_k = 0;
        in_drain = 1'b0;
        outstanding = 0;
        beats = 0;
        to_send = 0;
    endtask

    task automatic do_reset();
        rstn_i = 1'b0;
        valid_i = 1'b0;
        dp_valid_i = 1'b0;
        dp_gx_i = '0;
        dp_gy_i = '0;
        clear_model();
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
    endtask

    task automatic step();
        exp_t e;
        dp_ent_t de;
        int c, r, bi;
        logic k, s, l;
        @(negedge clk_i);
        valid_i = (to_send > 0);
        data_i  = pix_val;
        ready_i = !(cyc >= stall_from && cyc < stall_to);
        if (dp_q.size() > 0 && dp_q[0].due <= cyc) begin
            dp_valid_i = 1'b1;
            dp_gx_i = res_gx(dp_q[0].d);
            dp_gy_i = res_gy(dp_q[0].d);
        end else begin
            dp_valid_i = 1'b0;
            dp_gx_i = '0;
            dp_gy_i = '0;
        end
        #1;
        if (in_drain && !frame_done_o && valid_i) begin
            total++;
            if (ready_o !== 1'b0 || dp_valid_o !== 1'b0) begin
                bad++;
                $display("FAIL drain_gate: ready_o=%b dp_valid_o=%b want 0/0", ready_o, dp_valid_o);
            end
        end
        if (valid_i && !ready_o && !in_drain) begin
            total++;
            full_hits++;
            if (outstanding !== TD) begin
                bad++;
                $display("FAIL ready_drop: outstanding=%0d want %0d", outstanding, TD);
            end
        end
        if (valid_o && ready_i) begin
            bi = beats % FB;
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL extra_beat: got gx=%0h want no beat", gx_o);
            end else begin
                e = sb_q.pop_front();
                if (gx_o !== e.gx || gy_o !== e.gy || sof_o !== e.sof || eol_o !== e.eol) begin
                    bad++;
                    $display("FAIL beat%0d: got gx=%0h gy=%0h sof=%b eol=%b want %0h %0h %b %b",
                             bi, gx_o, gy_o, sof_o, eol_o, e.gx, e.gy, e.sof, e.eol);
                end
            end
            total++;
            if (sof_o !== (bi == 0)) begin
                bad++;
                $display("FAIL sof_pos beat%0d: got %b want %b", bi, sof_o, bi == 0);
            end
            total++;
            if (eol_o !== ((bi % OUT_W) == OUT_W - 1)) begin
                bad++;
                $display("FAIL eol_pos beat%0d: got %b want %b", bi, eol_o,
                         (bi % OUT_W) == OUT_W - 1);
            end
            beats++;
            last_beat_cyc = cyc;
        end
        if (dp_valid_i && dp_ready_o) begin
            de = dp_q.pop_front();
            outstanding--;
        end
        if (frame_done_o) begin
            total++;
            if (!in_drain || sb_q.size() != 0) begin
                bad++;
                $display("FAIL frame_done: got pulse in_drain=%b pending=%0d want drain/0",
                         in_drain, sb_q.size());
            end
            done_cnt++;
            done_cyc = cyc;
            in_drain = 1'b0;
        end
        if (valid_i && ready_o) begin
            c = pix_k % W;
            r = pix_k / W;
            k = (c >= 2) && (r >= 2);
`ifdef SOBEL_CTRL_BORDER_ZERO_EN
            s = (c == 0) && (r == 0);
            l = (c == W - 1);
            e.gx = k ? res_gx(pix_val) : 16'sd0;
            e.gy = k ? res_gy(pix_val) : 16'sd0;
            e.sof = s;
            e.eol = l;
            sb_q.push_back(e);
`else
            s = (c == 2) && (r == 2);
            l = k && (c == W - 1);
            e.gx = res_gx(pix_val);
            e.gy = res_gy(pix_val);
            e.sof = s;
            e.eol = l;
            if (k) sb_q.push_back(e);
`endif
            de.d = pix_val;
            de.due = cyc + LAT;
            dp_q.push_back(de);
            outstanding++;
            to_send--;
            pix_val++;
            if (pix_k == W * H - 1) begin
                pix_k = 0;
                in_drain = 1'b1;
            end else begin
                pix_k++;
            end
        end
        cyc++;
    endtask

    task automatic run_frames(input int n_pix, input int n_done, input int st_rel,
                              input int st_len);
        int target, guard;
        to_send = n_pix;
        target = done_cnt + n_done;
        stall_from = cyc + st_rel;
        stall_to = stall_from + st_len;
        guard = 0;
        while (done_cnt < target && guard < 400) begin
            step();
            guard++;
        end
        stall_to = 0;
        total++;
        if (done_cnt < target) begin
            bad++;
            $display("FAIL timeout: got %0d frame_done want %0d", done_cnt, target);
        end
    endtask

    task automatic check_frame_end(input int b0, input string name);
        total++;
        if (beats - b0 !== FB) begin
            bad++;
            $display("FAIL %s_beats: got %0d want %0d", name, beats - b0, FB);
        end
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL %s_lost: got %0d pending want 0", name, sb_q.size());
        end
        total++;
        if (done_cyc <= last_beat_cyc) begin
            bad++;
            $display("FAIL %s_done_order: got done@%0d want after beat@%0d", name, done_cyc,
                     last_beat_cyc);
        end
        repeat (2) step();
        total++;
        if (busy_o !== 1'b0 || frame_done_o !== 1'b0) begin
            bad++;
            $display("FAIL %s_idle: got busy=%b done=%b want 0/0", name, busy_o, frame_done_o);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        total++;
        if ({ready_o, dp_valid_o, valid_o, busy_o, frame_done_o, err_o, sof_o, eol_o} !== 8'h00) begin
            bad++;
            $display("FAIL %s_outs: got %b want 00000000", name,
                     {ready_o, dp_valid_o, valid_o, busy_o, frame_done_o, err_o, sof_o, eol_o});
        end
        total++;
        if (dp_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL %s_dp_ready: got %b want 1", name, dp_ready_o);
        end
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        valid_i = 1'b0;
        data_i = '0;
        dp_ready_i = 1'b0;
        dp_valid_i = 1'b0;
        dp_gx_i = '0;
        dp_gy_i = '0;
        ready_i = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk_i);
        rstn_i = 1'b1;
        dp_ready_i = 1'b1;
        #1;
        total++;
        if (ready_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready_open: got %b want 1", ready_o);
        end
    endtask

    task automatic test_frame();
        int b0;
        b0 = beats;
        run_frames(W * H, 1, 0, 0);
        check_frame_end(b0, "frame");
    endtask

    task automatic test_stall();
        int b0;
        b0 = beats;
        full_hits = 0;
        run_frames(W * H, 1, 12, 10);
        check_frame_end(b0, "stall");
        total++;
        if (full_hits == 0) begin
            bad++;
            $display("FAIL stall_full: got %0d ready drops want >0", full_hits);
        end
    endtask

    task automatic test_back_to_back();
        int b0;
        b0 = beats;
        run_frames(2 * W * H, 2, 0, 0);
        total++;
        if (beats - b0 !== 2 * FB) begin
            bad++;
            $display("FAIL b2b_beats: got %0d want %0d", beats - b0, 2 * FB);
        end
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_lost: got %0d pending want 0", sb_q.size());
        end
    endtask

    task automatic test_async_reset();
        int b0, d0;
        to_send = 7;
        repeat (8) step();
        @(posedge clk_i);
        #3;
        dp_valid_i = 1'b1;
        valid_i = 1'b0;
        dp_ready_i = 1'b0;
        rstn_i = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        clear_model();
        dp_valid_i = 1'b0;
        dp_ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
        d0 = done_cnt;
        repeat (5) step();
        total++;
        if (done_cnt !== d0) begin
            bad++;
            $display("FAIL async_rst_no_done: got %0d pulses want 0", done_cnt - d0);
        end
        b0 = beats;
        run_frames(W * H, 1, 0, 0);
        check_frame_end(b0, "post_rst");
    endtask

    task automatic test_err();
        @(negedge clk_i);
        dp_valid_i = 1'b1;
        #1;
        total++;
        if (valid_o !== 1'b0 || dp_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL err_inject: got valid_o=%b dp_ready_o=%b want 0/1", valid_o, dp_ready_o);
        end
        @(negedge clk_i);
        dp_valid_i = 1'b0;
        #1;
        total++;
        if (err_o !== 1'b1) begin
            bad++;
            $display("FAIL err_rise: got %b want 1", err_o);
        end
        repeat (5) @(negedge clk_i);
        #1;
        total++;
        if (err_o !== 1'b1 || valid_o !== 1'b0) begin
            bad++;
            $display("FAIL err_sticky: got err=%b valid_o=%b want 1/0", err_o, valid_o);
        end
        do_reset();
        #1;
        total++;
        if (err_o !== 1'b0) begin
            bad++;
            $display("FAIL err_clear: got %b want 0", err_o);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_stall();
        test_back_to_back();
        test_async_reset();
        test_err();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
